ics_uart_rx: RTL and testbench

ICS_UART_RX -- requirements
Module: ics_uart_rx

---
 rtl/ics_uart_rx.sv | 85 ++++++++
 tb/tb_ics_uart_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ics_uart_rx.sv
// ics_uart_rx: 8E1 serial receiver with 2-flop input synchronizer, parity and framing checks.
module ics_uart_rx #(
    parameter int CLKS_PER_BIT = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, BREAK = 3'd5;
    logic [1:0] sync;
    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [2:0] bcnt;
    logic [7:0] shift;
    logic par;
    logic rx_s;
    logic tick;
    assign rx_s = sync[1];
    assign tick = cnt == '0;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            bcnt <= '0;
            shift <= '0;
            par <= 1'b0;
            data_out <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err <= 1'b0;
            if (!tick) cnt <= cnt - 1'b1;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    bcnt <= '0;
                    cnt <= HALF_M1;
                end
                START: if (tick) begin
                    state <= rx_s ? IDLE : DATA;
                    cnt <= FULL_M1;
                end
                DATA: if (tick) begin
                    shift <= {rx_s, shift[7:1]};
                    bcnt <= bcnt + 1'b1;
                    cnt <= FULL_M1;
                    if (bcnt == 3'd7) state <= PARITY;
                end
                PARITY: if (tick) begin
                    par <= rx_s;
                    cnt <= FULL_M1;
                    state <= STOP;
                end
                STOP: if (tick) begin
                    data_out <= shift;
                    // A low stop bit parks in BREAK so a held-low line cannot look like a new start
                    if (rx_s) begin
                        parity_err <= ^{shift, par};
                        data_valid <= ~^{shift, par};
                        state <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state <= BREAK;
                    end
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ics_uart_rx.sv
// tb_ics_uart_rx: directed and randomized frame checks against a frame-level reference model.
module tb_ics_uart_rx;
    localparam int C = 8;
    localparam int LAT = 2 + C / 2 + 10 * C + 1;
    logic clk = 1'b0, rst = 1'b0, rx = 1'b1;
    logic [7:0] data_out;
    logic data_valid, parity_err, frame_err, busy;
    int checks = 0, errors = 0, cyc = 0;
    logic multi = 1'b0;
    typedef struct {int kind; logic [7:0] d; int cyc;} ev_t;
    ev_t evq[$];

    ics_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
        .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // kind: 1 = good byte, 2 = parity error, 3 = framing error
    always @(negedge clk) begin
        if (int'(data_valid) + int'(parity_err) + int'(frame_err) > 1) multi = 1'b1;
        if (data_valid) evq.push_back('{1, data_out, cyc});
        if (parity_err) evq.push_back('{2, data_out, cyc});
        if (frame_err) evq.push_back('{3, data_out, cyc});
    end

    function automatic int model_kind(input logic [7:0] d, input logic p, input logic s);
        if (!s) return 3;
        return (($countones(d) + int'(p)) % 2 == 0) ? 1 : 2;
    endfunction

    task automatic drive_bit(input logic v);
        @(negedge clk) rx = v;
        repeat (C - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int t0);
        @(negedge clk) rx = 1'b0;
        t0 = cyc;
        repeat (C - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got data_out=%h dv=%b pe=%b fe=%b busy=%b, expected all zero",
                     data_out, data_valid, parity_err, frame_err, busy);
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        checks++;
        if (evq.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got %0d pulses busy=%b, expected 0 pulses busy=0", evq.size(), busy);
        end
        idle(4);
    endtask

    task automatic test_good;
        int t0, n, k, c;
        logic [7:0] d;
        evq.delete();
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        idle(3);
        n = evq.size();
        k = n > 0 ? evq[0].kind : 0;
        d = n > 0 ? evq[0].d : 8'h00;
        c = n > 0 ? evq[0].cyc : 0;
        checks++;
        if (n != 1 || k != 1 || d !== 8'hA5) begin
            errors++;
            $display("FAIL good_frame: got %0d events kind=%0d data=%h, expected 1 event kind=1 data=a5", n, k, d);
        end
        checks++;
        if (c < t0 + LAT - 1 || c > t0 + LAT + 1) begin
            errors++;
            $display("FAIL good_latency: got %0d cycles, expected %0d +/-1", c - t0, LAT);
        end
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL good_hold: got data_out=%h, expected a5", data_out);
        end
    endtask

    task automatic test_parity;
        int t0, n, k;
        logic [7:0] d;
        evq.delete();
        send_frame(8'h01, 1'b0, 1'b1, t0);
        idle(3);
        n = evq.size();
        k = n > 0 ? evq[0].kind : 0;
        d = n > 0 ? evq[0].d : 8'h00;
        checks++;
        if (n != 1 || k != 2 || d !== 8'h01) begin
            errors++;
            $display("FAIL parity_frame: got %0d events kind=%0d data=%h, expected 1 event kind=2 data=01", n, k, d);
        end
    endtask

    task automatic test_frame_err;
        int t0, n, k;
        logic [7:0] d;
        logic bad;
        evq.delete();
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b1 || evq.size() > 1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL break_hold: got busy low or extra pulse during low line (%0d events), expected busy=1 and 1 event", evq.size());
        end
        idle(4);
        n = evq.size();
        k = n > 0 ? evq[0].kind : 0;
        d = n > 0 ? evq[0].d : 8'h00;
        checks++;
        if (n != 1 || k != 3 || d !== 8'h3C) begin
            errors++;
            $display("FAIL frame_err: got %0d events kind=%0d data=%h, expected 1 event kind=3 data=3c", n, k, d);
        end
        checks++;
        if (busy !== 1'b0 || data_out !== 8'h3C) begin
            errors++;
            $display("FAIL break_exit: got busy=%b data_out=%h, expected busy=0 data_out=3c", busy, data_out);
        end
    endtask

    task automatic test_glitch;
        evq.delete();
        @(negedge clk) rx = 1'b0;
        @(negedge clk);
        @(negedge clk) rx = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: got busy=%b, expected 1", busy);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || evq.size() != 0) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b events=%0d, expected busy=0 events=0", busy, evq.size());
        end
    endtask

    task automatic test_back_to_back;
        int t0, t1, n;
        evq.delete();
        send_frame(8'h12, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t1);
        idle(3);
        n = evq.size();
        checks++;
        if (n != 2 || evq[0].kind != 1 || evq[0].d !== 8'h12 || evq[1].kind != 1 || evq[1].d !== 8'hFF) begin
            errors++;
            $display("FAIL back_to_back: got %0d events, expected 2 good events data=12 then ff", n);
        end
        checks++;
        if (n != 2 || evq[1].cyc < t1 + LAT - 1 || evq[1].cyc > t1 + LAT + 1) begin
            errors++;
            $display("FAIL b2b_latency: got %0d events, second frame latency off from %0d", n, LAT);
        end
    endtask

    task automatic test_reset_midframe;
        int t0, n, k;
        logic [7:0] d;
        logic [7:0] b;
        evq.delete();
        b = 8'h55;
        @(negedge clk) rx = 1'b0;
        repeat (C - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        @(negedge clk) rx = b[4];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset: got data_out=%h dv=%b pe=%b fe=%b busy=%b, expected all zero",
                     data_out, data_valid, parity_err, frame_err, busy);
        end
        rst = 1'b1;
        idle(5);
        send_frame(8'hC3, 1'b0, 1'b1, t0);
        idle(3);
        n = evq.size();
        k = n > 0 ? evq[0].kind : 0;
        d = n > 0 ? evq[0].d : 8'h00;
        checks++;
        if (n != 1 || k != 1 || d !== 8'hC3) begin
            errors++;
            $display("FAIL after_reset_frame: got %0d events kind=%0d data=%h, expected 1 event kind=1 data=c3", n, k, d);
        end
    endtask

    task automatic test_random;
        int t0, n, k, c, ek;
        logic [7:0] d, rd;
        logic p, s;
        for (int f = 0; f < 24; f++) begin
            evq.delete();
            rd = 8'($urandom_range(0, 255));
            p = 1'($countones(rd) % 2) ^ ($urandom_range(0, 3) == 0);
            s = $urandom_range(0, 4) != 0;
            ek = model_kind(rd, p, s);
            send_frame(rd, p, s, t0);
            if (!s) repeat ($urandom_range(0, 20)) @(negedge clk);
            idle(4);
            n = evq.size();
            k = n > 0 ? evq[0].kind : 0;
            d = n > 0 ? evq[0].d : 8'h00;
            c = n > 0 ? evq[0].cyc : 0;
            checks++;
            if (n != 1 || k != ek || d !== rd || busy !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d: got %0d events kind=%0d data=%h busy=%b, expected kind=%0d data=%h busy=0",
                         f, n, k, d, busy, ek, rd);
            end
            checks++;
            if (c < t0 + LAT - 1 || c > t0 + LAT + 1) begin
                errors++;
                $display("FAIL random_latency_%0d: got %0d cycles, expected %0d +/-1", f, c - t0, LAT);
            end
            idle($urandom_range(0, 12));
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        checks++;
        if (multi !== 1'b0) begin
            errors++;
            $display("FAIL exclusive_pulses: got overlapping pulses, expected at most one per cycle");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
